instr_fetch: RTL and testbench

Instruction fetch stage feeding the 8-bit accumulator core. Holds program memory, written through a loader port and read at the core's `pc` once execution starts. It returns the 11-bit instruction word one cycle later with a valid flag. It stops issuing on an HLT opcode and counts delivered instructions for debug.

---
 rtl/instr_fetch_if.sv | 29 ++
 rtl/instr_fetch.sv | 110 +++++++++++
 tb/tb_instr_fetch.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_if.sv
// Bundle between the fetch stage, the program loader and the core.
// The loader and core drive through the master modport, and the fetch stage uses the slave modport.
interface instr_fetch_if #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 11,
    parameter int CNT_W   = 16
);
    logic               load_en;
    logic               load_we;
    logic [ADDR_W-1:0]  load_addr;
    logic [INSTR_W-1:0] load_data;
    logic               start;
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
    logic               instr_valid;
    logic               running;
    logic               halted;
    logic [CNT_W-1:0]   fetch_count;

    modport master (
        output load_en, load_we, load_addr, load_data, start, pc,
        input  instr, instr_valid, running, halted, fetch_count
    );

    modport slave (
        input  load_en, load_we, load_addr, load_data, start, pc,
        output instr, instr_valid, running, halted, fetch_count
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage for the 8-bit accumulator core.
// Program memory is written by the loader and read at the core's pc while running.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   IDLE   | after reset, waiting for a load request or a start
//   LOAD   | loader owns the memory, and writes are honoured
//   RUN    | mem[pc] is registered every cycle; the first cycle is not valid
//   HALT   | an HLT word was delivered; the fetch count is frozen
module instr_fetch #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 11,
    parameter int DEPTH   = 256,
    parameter int CNT_W   = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    instr_fetch_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_HALT = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t             r_state;
    state_t             w_state_nxt;
    logic [INSTR_W-1:0] r_mem [DEPTH];
    logic [INSTR_W-1:0] r_instr;
    logic [INSTR_W-1:0] w_instr_nxt;
    logic               r_valid;
    logic               w_valid_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_we;
    logic               w_hlt;

    // Writes are accepted only in LOAD. This includes the cycle in which load_en drops.
    assign w_we  = (r_state == S_LOAD) && bus.load_we;
    // The word currently on the bus is an HLT. Exactly one HLT word is presented before the stage stops.
    assign w_hlt = r_valid && (r_instr[2:0] == 3'h0);

    // Program memory has no reset, so its contents survive rst_n.
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[bus.load_addr] <= bus.load_data;
        end
    end

    // State and output registers. All of them clear asynchronously, so outputs drop as soon as reset is asserted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_instr <= '0;
            r_valid <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_instr <= w_instr_nxt;
            r_valid <= w_valid_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next state, next fetched word and the saturating delivered-word count.
    always_comb begin
        w_state_nxt = r_state;
        w_instr_nxt = '0;
        w_valid_nxt = 1'b0;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE, S_HALT: begin
                if (bus.load_en) begin
                    w_state_nxt = S_LOAD;
                end else if (bus.start) begin
                    w_state_nxt = S_RUN;
                    w_cnt_nxt   = '0;
                end
            end
            S_LOAD: begin
                if (!bus.load_en) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RUN: begin
                if (w_hlt) begin
                    w_state_nxt = S_HALT;
                end else begin
                    w_instr_nxt = r_mem[bus.pc];
                    w_valid_nxt = 1'b1;
                    if (r_cnt != '1) begin
                        w_cnt_nxt = r_cnt + CNT_ONE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.instr       = r_instr;
    assign bus.instr_valid = r_valid;
    assign bus.running     = (r_state == S_RUN);
    assign bus.halted      = (r_state == S_HALT);
    assign bus.fetch_count = r_cnt;
endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch. The reference model is a plain memory image.
// A run delivers mem[pc] for each cycle's pc up to and including the first HLT word.
// The count saturates at all-ones, and CNT_W is 4 here.
module tb_instr_fetch;
    localparam int ADDR_W  = 8;
    localparam int INSTR_W = 11;
    localparam int DEPTH   = 256;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = 15;

    logic clk;
    logic rst_n;

    instr_fetch_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .CNT_W(CNT_W)) bus ();

    instr_fetch #(
        .ADDR_W (ADDR_W),
        .INSTR_W(INSTR_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [INSTR_W-1:0] mem_m [DEPTH];
    int n_vec = 0;
    int n_err = 0;
    int exp_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag, input int cnt);
        chk({tag, "_instr"}, 32'(bus.instr), 32'd0);
        chk({tag, "_valid"}, 32'(bus.instr_valid), 32'd0);
        chk({tag, "_running"}, 32'(bus.running), 32'd0);
        chk({tag, "_halted"}, 32'(bus.halted), 32'd0);
        chk({tag, "_count"}, 32'(bus.fetch_count), 32'(cnt));
    endtask

    task automatic clear_inputs();
        bus.load_en   = 1'b0;
        bus.load_we   = 1'b0;
        bus.load_addr = '0;
        bus.load_data = '0;
        bus.start     = 1'b0;
        bus.pc        = '0;
    endtask

    // Assert reset between two edges and check that the outputs fall before the next edge.
    task automatic mid_reset(input string tag);
        clear_inputs();
        #2 rst_n = 1'b0;
        #1;
        exp_cnt = 0;
        chk_quiet({tag, "_async"}, 0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        chk_quiet({tag, "_post"}, 0);
    endtask

    // Enter LOAD, write n words, and drop load_en together with the final write.
    task automatic load_words(input logic [ADDR_W-1:0] addr[$], input logic [INSTR_W-1:0] data[$]);
        bus.load_en = 1'b1;
        @(posedge clk); #1;
        chk("load_enter_running", 32'(bus.running), 32'd0);
        chk("load_enter_halted", 32'(bus.halted), 32'd0);
        bus.start = 1'b0;
        for (int i = 0; i < addr.size(); i++) begin
            bus.load_we   = 1'b1;
            bus.load_addr = addr[i];
            bus.load_data = data[i];
            if (i == addr.size() - 1) bus.load_en = 1'b0;
            mem_m[addr[i]] = data[i];
            @(posedge clk); #1;
        end
        bus.load_we = 1'b0;
        @(posedge clk); #1;
        chk_quiet("load_exit", exp_cnt);
    endtask

    // mode 0: random pc with junk loader/start activity, 1: pc = 0,1,2,..., 2: pc fixed at 5.
    // Returns whether an HLT word ended the run.
    task automatic run_prog(input int mode, input int n_max, output bit done);
        logic [ADDR_W-1:0]  p;
        logic [INSTR_W-1:0] w;
        int k;
        bus.start = 1'b1;
        bus.pc    = ADDR_W'($urandom);
        @(posedge clk); #1;
        bus.start = 1'b0;
        exp_cnt = 0;
        chk("run_enter_running", 32'(bus.running), 32'd1);
        chk("run_enter_valid", 32'(bus.instr_valid), 32'd0);
        chk("run_enter_instr", 32'(bus.instr), 32'd0);
        chk("run_enter_count", 32'(bus.fetch_count), 32'd0);
        done = 1'b0;
        k = 0;
        while (!done && k < n_max) begin
            case (mode)
                1:       p = ADDR_W'(k);
                2:       p = 8'd5;
                default: p = ADDR_W'($urandom);
            endcase
            if (mode == 0) begin
                bus.load_en   = 1'($urandom_range(0, 1));
                bus.start     = 1'($urandom_range(0, 1));
                bus.load_we   = 1'b1;
                bus.load_addr = ($urandom_range(0, 1) == 1) ? 8'd5 : ADDR_W'($urandom);
                bus.load_data = ~mem_m[bus.load_addr];
            end
            bus.pc = p;
            @(posedge clk); #1;
            w = mem_m[p];
            chk("run_instr", 32'(bus.instr), 32'(w));
            chk("run_valid", 32'(bus.instr_valid), 32'd1);
            chk("run_running", 32'(bus.running), 32'd1);
            if (exp_cnt < CNT_MAX) exp_cnt++;
            k++;
            if (w[2:0] == 3'h0) done = 1'b1;
        end
        if (done) begin
            clear_inputs();
            bus.pc = ADDR_W'($urandom);
            @(posedge clk); #1;
            chk("halt_halted", 32'(bus.halted), 32'd1);
            chk("halt_running", 32'(bus.running), 32'd0);
            chk("halt_valid", 32'(bus.instr_valid), 32'd0);
            chk("halt_instr", 32'(bus.instr), 32'd0);
            chk("halt_count", 32'(bus.fetch_count), 32'(exp_cnt));
            @(posedge clk); #1;
            chk("halt_hold_count", 32'(bus.fetch_count), 32'(exp_cnt));
            chk("halt_hold_halted", 32'(bus.halted), 32'd1);
        end
    endtask

    initial begin
        logic [ADDR_W-1:0]  a_q[$];
        logic [INSTR_W-1:0] d_q[$];
        bit done;

        rst_n = 1'b0;
        clear_inputs();
        repeat (3) @(posedge clk);
        #1;
        chk_quiet("reset", 0);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk_quiet("idle", 0);
        end

        // load_en wins over start in IDLE
        bus.start = 1'b1;
        a_q = '{8'd0, 8'd1, 8'd2};
        d_q = '{11'h009, 11'h00A, 11'h000};
        load_words(a_q, d_q);

        run_prog(1, 10, done);
        chk("first_run_halted", 32'(done), 32'd1);
        chk("first_run_count", 32'(bus.fetch_count), 32'd3);
        run_prog(1, 10, done);
        chk("restart_count", 32'(bus.fetch_count), 32'd3);

        // Random program over the whole memory, then random runs with junk writes in RUN
        a_q.delete();
        d_q.delete();
        for (int i = 0; i < DEPTH; i++) begin
            a_q.push_back(ADDR_W'(i));
            d_q.push_back((i == 5) ? 11'h00D : INSTR_W'($urandom));
        end
        load_words(a_q, d_q);
        for (int r = 0; r < 6; r++) begin
            run_prog(0, 300, done);
            if (!done) mid_reset("rand_abort");
        end
        run_prog(2, 4, done);
        mid_reset("addr5_reset");

        // Asynchronous reset mid-run, then the program must come back intact
        a_q = '{8'd0, 8'd1, 8'd2, 8'd3};
        d_q = '{11'h011, 11'h01A, 11'h123, 11'h7F9};
        load_words(a_q, d_q);
        run_prog(1, 3, done);
        mid_reset("run_reset");
        run_prog(1, 4, done);
        mid_reset("run_reset2");

        // All non-HLT words with pc wrapping twice, and the count saturates
        a_q.delete();
        d_q.delete();
        for (int i = 0; i < DEPTH; i++) begin
            a_q.push_back(ADDR_W'(i));
            d_q.push_back(11'h001);
        end
        load_words(a_q, d_q);
        run_prog(1, 2 * DEPTH, done);
        chk("wrap_no_halt", 32'(done), 32'd0);
        chk("sat_count", 32'(bus.fetch_count), 32'(CNT_MAX));
        mid_reset("wrap_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
